inst_loader: RTL

Boot-time instruction loader for the S-Machine. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes them into instruction memory at incrementing addresses from 0, and holds the CPU disabled until the programmed word count has been written. It is the write side of instruction memory, which the CPU only reads through PC/inst. It sits between an external byte source and the InstMemory write port, and drives the CPU `enable`.

---
 rtl/inst_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - boot-time loader: byte stream to 16-bit big-endian instruction-memory writes
module inst_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_WIDTH-1:0] imem_wdata,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   last_idx;
  logic [7:0]            hi_byte;
  logic                  length_ok;
  logic                  xfer;

  assign length_ok  = (length != '0) && (length <= MAX_LEN);
  // Ready depends only on registered state, so no input reaches an output.
  assign byte_ready = (state == S_HI) || (state == S_LO);
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      last_idx   <= '0;
      hi_byte    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done       <= 1'b0;
            cpu_enable <= 1'b0;
            if (length_ok) begin
              last_idx <= length - ONE;
              count    <= '0;
              error    <= 1'b0;
              busy     <= 1'b1;
              state    <= S_HI;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_byte <= byte_in;
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            imem_wdata <= {hi_byte, byte_in};
            imem_addr  <= count[ADDR_WIDTH-1:0];
            imem_we    <= 1'b1;
            state      <= S_WR;
          end
        end
        S_WR: begin
          imem_we <= 1'b0;
          if (count == last_idx) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_enable <= 1'b1;
            state      <= S_DONE;
          end else begin
            count <= count + ONE;
            state <= S_HI;
          end
        end
        default: begin
          imem_we <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
